// File: rtl/dot_sequencer.sv
// Purpose: runs a K-chunk dot product through one shared N-lane float dot-product
//          tree and accumulates the chunk partial sums with a single float adder.
// Latency: 3 cycles per chunk (LOAD->MUL->ACC); K=1 gives a result 4 cycles after start, K=0 after 1.
// Backpressure: start_ready/chunk_ready/res_valid are pure state decodes; DONE holds the result until res_ready.
//
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   start_valid/start_ready          job request handshake, start_chunks = K sampled on it
//   chunk_valid/chunk_ready          operand chunk handshake, chunk_a/chunk_b = N packed 27-bit floats
//   res_valid/res_ready, res_data    result handshake, res_data is the accumulator register
//   busy                             high in every state except IDLE
//
// Float format: {sign, exp[7:0] bias 127, frac[17:0]}; exp==0 is treated as zero.
// Mul/add truncate, underflow flushes to +0 and overflow saturates to the largest finite value.

module dot_sequencer #(
    parameter int N     = 32,
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [LEN_W-1:0]  start_chunks,
    input  logic              chunk_valid,
    output logic              chunk_ready,
    input  logic [27*N-1:0]   chunk_a,
    input  logic [27*N-1:0]   chunk_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [26:0]       res_data,
    output logic              busy
);

    localparam int LOG_N = $clog2(N);

    typedef enum logic [2:0] {IDLE, LOAD, MUL, ACC, DONE} state_t;

    state_t            state;
    state_t            nextState;
    logic [27*N-1:0]   opa_r;
    logic [27*N-1:0]   opb_r;
    logic [26:0]       prod_r;
    logic [26:0]       acc_r;
    logic [LEN_W-1:0]  rem_r;
    logic [26:0]       dotOut;
    logic [26:0]       accSum;
    logic              startTake;
    logic              chunkTake;

    // Float multiply: 19x19 significand product, one-step normalisation.
    function automatic logic [26:0] fpMul(input logic [26:0] a, input logic [26:0] b);
        logic [37:0]       p;
        logic signed [9:0] e;
        logic [17:0]       f;
        p = {1'b1, a[17:0]} * {1'b1, b[17:0]};
        e = $signed({2'b00, a[25:18]}) + $signed({2'b00, b[25:18]}) - 10'sd127;
        if (p[37]) begin
            f = p[36:19];
            e = e + 10'sd1;
        end else begin
            f = p[35:18];
        end
        if (a[25:18] == 8'd0 || b[25:18] == 8'd0 || e <= 10'sd0)
            fpMul = 27'h0;
        else if (e >= 10'sd255)
            fpMul = {a[26] ^ b[26], 8'hFE, 18'h3FFFF};
        else
            fpMul = {a[26] ^ b[26], e[7:0], f};
    endfunction

    // Float add: order operands by magnitude so the subtraction never goes negative,
    // align with 3 extra low bits, then renormalise by at most one right shift or
    // a leading-zero walk to the left.
    function automatic logic [26:0] fpAdd(input logic [26:0] a, input logic [26:0] b);
        logic [26:0]       big;
        logic [26:0]       sml;
        logic [7:0]        d;
        logic [22:0]       mb;
        logic [22:0]       ms;
        logic [22:0]       s;
        logic signed [9:0] e;
        if (a[25:18] == 8'd0) begin
            fpAdd = b;
        end else if (b[25:18] == 8'd0) begin
            fpAdd = a;
        end else begin
            if (a[25:0] >= b[25:0]) begin
                big = a;
                sml = b;
            end else begin
                big = b;
                sml = a;
            end
            d  = big[25:18] - sml[25:18];
            mb = {2'b01, big[17:0], 3'b000};
            ms = {2'b01, sml[17:0], 3'b000} >> d;
            s  = (big[26] == sml[26]) ? (mb + ms) : (mb - ms);
            e  = $signed({2'b00, big[25:18]});
            if (s[22]) begin
                s = s >> 1;
                e = e + 10'sd1;
            end
            for (int i = 0; i < 22; i++) begin
                if (!s[21]) begin
                    s = s << 1;
                    e = e - 10'sd1;
                end
            end
            if (s == 23'd0 || e <= 10'sd0)
                fpAdd = 27'h0;
            else if (e >= 10'sd255)
                fpAdd = {big[26], 8'hFE, 18'h3FFFF};
            else
                fpAdd = {big[26], e[7:0], s[20:3]};
        end
    endfunction

    // N products reduced by a balanced pairwise tree, in place: level lv folds the
    // first N>>lv entries into N>>(lv+1); slot i is only overwritten after slots
    // 2i and 2i+1 have been read.
    function automatic logic [26:0] dotProduct(input logic [27*N-1:0] a, input logic [27*N-1:0] b);
        logic [26:0] t [N];
        for (int i = 0; i < N; i++)
            t[i] = fpMul(a[27*i +: 27], b[27*i +: 27]);
        for (int lv = 0; lv < LOG_N; lv++)
            for (int i = 0; i < N / 2; i++)
                if (i < (N >> (lv + 1)))
                    t[i] = fpAdd(t[2*i], t[2*i+1]);
        dotProduct = t[0];
    endfunction

    assign dotOut   = dotProduct(opa_r, opb_r);
    assign accSum   = fpAdd(acc_r, prod_r);
    assign res_data = acc_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState   = state;
        start_ready = 1'b0;
        chunk_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b1;
        startTake   = 1'b0;
        chunkTake   = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (start_valid) begin
                    startTake = 1'b1;
                    nextState = (start_chunks == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                chunk_ready = 1'b1;
                if (chunk_valid) begin
                    chunkTake = 1'b1;
                    nextState = MUL;
                end
            end
            MUL:  nextState = ACC;
            // rem_r was already decremented when this chunk was taken.
            ACC:  nextState = (rem_r == '0) ? DONE : LOAD;
            DONE: begin
                res_valid = 1'b1;
                if (res_ready)
                    nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opa_r  <= '0;
            opb_r  <= '0;
            prod_r <= '0;
            acc_r  <= '0;
            rem_r  <= '0;
        end else begin
            if (startTake) begin
                acc_r <= 27'h0;
                rem_r <= start_chunks;
            end
            if (chunkTake) begin
                opa_r <= chunk_a;
                opb_r <= chunk_b;
                rem_r <= rem_r - 1'b1;
            end
            if (state == MUL)
                prod_r <= dotOut;
            if (state == ACC)
                acc_r <= accSum;
        end
    end

endmodule
